pc_fetch_ctrl: RTL

Program-counter and next-PC control for the IF stage of the five-stage RV32I pipeline. It sits directly downstream of the EX-stage branch unit and consumes its resolved `branch`/`jump` outputs and computed target. It holds the PC register, applies load-use stalls, and redirects fetch on a mispredicted or taken control transfer, raising flushes for the IF/ID and ID/EX registers. It optionally predicts conditional branches with a direct-mapped BTB and keeps branch/mispredict counters for the debug bus.

---
 rtl/pc_fetch_ctrl_if.sv | 30 +++
 rtl/pc_fetch_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus between the EX-stage branch unit / hazard unit and the IF-stage PC logic.
// The DUT takes the slave modport; the environment driving EX results takes the master modport.
interface pc_fetch_ctrl_if;
  // EX-stage resolution and hazard inputs to the PC logic
  logic        stall;
  logic        branch;
  logic        jump;
  logic [31:0] target;
  logic [31:0] pc_ex;
  logic        ex_is_branch;
  logic        ex_pred_taken;

  // Fetch-side results
  logic [31:0] pc_if;
  logic        pred_taken;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  modport master (
    output stall, branch, jump, target, pc_ex, ex_is_branch, ex_pred_taken,
    input  pc_if, pred_taken, flush_if_id, flush_id_ex, br_cnt, mis_cnt
  );

  modport slave (
    input  stall, branch, jump, target, pc_ex, ex_is_branch, ex_pred_taken,
    output pc_if, pred_taken, flush_if_id, flush_id_ex, br_cnt, mis_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with redirect/stall handling, branch counters and an optional
// direct-mapped BTB predictor enabled by defining PC_FETCH_BTB_EN (static not-taken otherwise).
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_ctrl_if.slave bus
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [31:0] r_pc;
  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;

  logic        w_taken;
  logic        w_redirect;
  logic [31:0] w_correct_pc;
  logic [31:0] w_seq_pc;
  logic        w_pred;
  logic [31:0] w_pred_tgt;
  logic [31:0] w_next_pc;
  logic        w_unused;

  assign w_taken      = bus.branch | bus.jump;
  assign w_correct_pc = w_taken ? {bus.target[31:2], 2'b00} : (bus.pc_ex + 32'd4);
  assign w_seq_pc     = r_pc + 32'd4;

`ifdef PC_FETCH_BTB_EN
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAGW-1:0]        r_tag [BTB_ENTRIES];
  logic [31:0]            r_tgt [BTB_ENTRIES];
  logic [1:0]             r_ctr [BTB_ENTRIES];

  logic [IDX-1:0]  w_if_idx;
  logic [TAGW-1:0] w_if_tag;
  logic [IDX-1:0]  w_ex_idx;
  logic [TAGW-1:0] w_ex_tag;
  logic            w_if_hit;
  logic            w_ex_hit;

  assign w_if_idx = r_pc[IDX+1:2];
  assign w_if_tag = r_pc[31:IDX+2];
  assign w_ex_idx = bus.pc_ex[IDX+1:2];
  assign w_ex_tag = bus.pc_ex[31:IDX+2];

  assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_pred     = w_if_hit & r_ctr[w_if_idx][1];
  assign w_pred_tgt = r_tgt[w_if_idx];

  // A mismatch against the carried prediction is what costs a redirect, not the outcome itself.
  assign w_redirect = bus.ex_is_branch ? (bus.branch != bus.ex_pred_taken) : bus.jump;

  // Writes land at the edge, so a same-cycle lookup of this index still sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (bus.ex_is_branch) begin
      if (w_ex_hit) begin
        if (bus.branch && (r_ctr[w_ex_idx] != 2'b11)) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
        end else if (!bus.branch && (r_ctr[w_ex_idx] != 2'b00)) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
        end
      end else begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_tgt[w_ex_idx]   <= {bus.target[31:2], 2'b00};
        r_ctr[w_ex_idx]   <= bus.branch ? 2'b10 : 2'b01;
      end
    end
  end
`else
  assign w_pred     = 1'b0;
  assign w_pred_tgt = w_seq_pc;
  assign w_redirect = bus.branch | bus.jump;
`endif

  assign w_unused = ^{bus.target[1:0], bus.ex_pred_taken};

  // Priority: redirect, then stall, then prediction, then sequential fetch.
  always_comb begin
    w_next_pc = w_seq_pc;
    if (w_redirect) begin
      w_next_pc = w_correct_pc;
    end else if (bus.stall) begin
      w_next_pc = r_pc;
    end else if (w_pred) begin
      w_next_pc = w_pred_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (bus.ex_is_branch) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_redirect) begin
        r_mis_cnt <= r_mis_cnt + 32'd1;
      end
    end
  end

  assign bus.pc_if       = r_pc;
  assign bus.pred_taken  = w_pred;
  assign bus.flush_if_id = w_redirect;
  assign bus.flush_id_ex = w_redirect;
  assign bus.br_cnt      = r_br_cnt;
  assign bus.mis_cnt     = r_mis_cnt;

endmodule
